motion_window_gen: RTL

MOTION_WINDOW_GEN -- requirements
Module: motion_window_gen

---
 rtl/motion_window_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/motion_window_gen.sv
// 3x3 zero-padded motion window generator over a raster stream of motion bits.
// Latency: window centre trails input by IMG_WIDTH+1 pixels, output registered one cycle after the producing cycle.
// Backpressure: none on output; in_ready drops only while the tail of the frame is flushed with zero pseudo-pixels.
module motion_window_gen #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    localparam int XW  = $clog2(IMG_WIDTH),
    localparam int YW  = $clog2(IMG_HEIGHT),
    localparam int CYW = $clog2(IMG_HEIGHT + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          motion_bit,
    output logic          in_ready,
    output logic [8:0]    motion_map,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_last
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam logic [XW-1:0]  X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [CYW-1:0] Y_LAST = CYW'(IMG_HEIGHT - 1);
    // Flush ends on the pseudo-pixel at (0, IMG_HEIGHT+1), i.e. IMG_WIDTH+1 injections after the last real pixel.
    localparam logic [CYW-1:0] Y_END  = CYW'(IMG_HEIGHT + 1);

    state_t                 state_q, state_d;
    logic                   in_ready_q;
    logic [XW-1:0]          in_x_q;
    logic [CYW-1:0]         in_y_q;
    logic [IMG_WIDTH-1:0]   lb1_q, lb2_q;
    logic [2:0]             col_a_q, col_b_q;
    logic [8:0]             map_q;
    logic                   out_valid_q, out_last_q;
    logic [XW-1:0]          out_x_q;
    logic [YW-1:0]          out_y_q;

    logic                   accept, proc, pbit;
    logic [XW-1:0]          px, nx, cx;
    logic [CYW-1:0]         py, ny, cy;
    logic                   emit, keep_l, keep_r, keep_t, keep_b;
    logic [2:0]             col_new;
    logic [8:0]             map_d;

    assign accept = enable && in_valid && in_ready_q;

    // Decide whether a real or pseudo pixel is processed this cycle, at which position, and the next FSM state.
    always_comb begin
        proc    = 1'b0;
        pbit    = 1'b0;
        px      = in_x_q;
        py      = in_y_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && in_sof) begin
                    proc    = 1'b1;
                    pbit    = motion_bit;
                    px      = '0;
                    py      = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    proc = 1'b1;
                    pbit = motion_bit;
                    if (in_sof) begin
                        // Restart: stale line-buffer rows are never used thanks to the top-row edge mask.
                        px = '0;
                        py = '0;
                    end else if (in_x_q == X_LAST && in_y_q == Y_LAST) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (enable) begin
                    proc = 1'b1;
                    if (in_y_q == Y_END) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window datapath: next position, centre position, edge masks and the masked 3x3 map.
    always_comb begin
        nx      = (px == X_LAST) ? '0 : px + XW'(1);
        ny      = (px == X_LAST) ? py + CYW'(1) : py;
        cx      = (px == '0) ? X_LAST : px - XW'(1);
        cy      = (px == '0) ? py - CYW'(2) : py - CYW'(1);
        emit    = (py >= CYW'(2)) || (py == CYW'(1) && px != '0);
        keep_l  = (cx != '0);
        keep_r  = (cx != X_LAST);
        keep_t  = (cy != '0);
        keep_b  = (cy != Y_LAST);
        // Column bits: [2] row y-2, [1] row y-1, [0] current row.
        col_new = {lb2_q[px], lb1_q[px], pbit};
        map_d   = '0;
        map_d[0] = keep_t & keep_l & col_a_q[2];
        map_d[1] = keep_t & col_b_q[2];
        map_d[2] = keep_t & keep_r & col_new[2];
        map_d[3] = keep_l & col_a_q[1];
        map_d[4] = col_b_q[1];
        map_d[5] = keep_r & col_new[1];
        map_d[6] = keep_b & keep_l & col_a_q[0];
        map_d[7] = keep_b & col_b_q[0];
        map_d[8] = keep_b & keep_r & col_new[0];
    end

    // FSM, counters, line buffers, shift window and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            in_x_q      <= '0;
            in_y_q      <= '0;
            lb1_q       <= '0;
            lb2_q       <= '0;
            col_a_q     <= '0;
            col_b_q     <= '0;
            map_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FLUSH);
            out_valid_q <= proc && emit;
            out_last_q  <= proc && emit && (cx == X_LAST) && (cy == Y_LAST);
            if (proc) begin
                in_x_q      <= nx;
                in_y_q      <= ny;
                lb2_q[px]   <= lb1_q[px];
                lb1_q[px]   <= pbit;
                col_a_q     <= col_b_q;
                col_b_q     <= col_new;
            end
            if (proc && emit) begin
                map_q   <= map_d;
                out_x_q <= cx;
                out_y_q <= cy[YW-1:0];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign motion_map = map_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_last   = out_last_q;

endmodule
